// File: rtl/lighthouse_sweep_tx.sv
// Lighthouse v1 base-station sweep timing generator.
// Emits the coded sync flash, the emulated laser hit and the TS4231-style E line.
module lighthouse_sweep_tx #(
  parameter int CLK_SPEED    = 50_000_000,
  parameter int SWEEP_CYCLES = CLK_SPEED / 120,
  parameter int SYNC_BASE    = CLK_SPEED / 16000,
  parameter int SYNC_STEP    = CLK_SPEED / 96000,
  parameter int HIT_CYCLES   = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        skip_i,
  input  logic        ootx_valid_i,
  input  logic        ootx_bit_i,
  output logic        ootx_ready_o,
  input  logic [18:0] hit_x_i,
  input  logic [18:0] hit_y_i,
  output logic        sync_o,
  output logic        hit_o,
  output logic        env_n_o,
  output logic        axis_o,
  output logic        period_start_o
);

  localparam int LW = 21;
  localparam logic [18:0]   LAST = 19'(SWEEP_CYCLES - 1);
  localparam logic [LW-1:0] SB   = LW'(SYNC_BASE);
  localparam logic [LW-1:0] SS   = LW'(SYNC_STEP);
  localparam logic [LW-1:0] HC   = LW'(HIT_CYCLES);
  localparam logic [LW-1:0] SW   = LW'(SWEEP_CYCLES);
  localparam logic [LW-1:0] HMIN = LW'(SYNC_BASE + 8 * SYNC_STEP);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [18:0] cnt, cnt_n;
  logic [18:0] hoff, hoff_n;
  logic        axis, axis_n;
  logic        skip_q, skip_n;
  logic        data_q, data_n;
  logic        start;

  logic [LW-1:0] cnt_x, hoff_x, hend_x;
  logic [LW-1:0] code_x, sync_len;
  logic          run_n, hit_en;

  assign start        = enable_i & ((state == IDLE) | (cnt == LAST));
  assign ootx_ready_o = start;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    axis_n  = axis;
    skip_n  = skip_q;
    data_n  = data_q;
    hoff_n  = hoff;
    if (!enable_i) begin
      state_n = IDLE;
      cnt_n   = '0;
      axis_n  = 1'b0;
    end else if (state == IDLE) begin
      state_n = RUN;
      cnt_n   = '0;
      axis_n  = 1'b0;
    end else if (cnt == LAST) begin
      cnt_n  = '0;
      axis_n = ~axis;
    end else begin
      cnt_n = cnt + 19'd1;
    end
    // Per-period parameters are captured together on the start edge.
    if (start) begin
      skip_n = skip_i;
      data_n = ootx_valid_i & ootx_bit_i;
      hoff_n = axis_n ? hit_y_i : hit_x_i;
    end
  end

  assign run_n    = (state_n == RUN);
  assign cnt_x    = {2'b00, cnt_n};
  assign hoff_x   = {2'b00, hoff_n};
  assign hend_x   = hoff_x + HC;
  assign code_x   = {18'd0, skip_n, data_n, axis_n};
  assign sync_len = SB + code_x * SS;
  assign hit_en   = !skip_n && (hoff_x >= HMIN) && (hend_x <= SW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      axis           <= 1'b0;
      skip_q         <= 1'b0;
      data_q         <= 1'b0;
      hoff           <= '0;
      sync_o         <= 1'b0;
      hit_o          <= 1'b0;
      env_n_o        <= 1'b1;
      axis_o         <= 1'b0;
      period_start_o <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      axis           <= axis_n;
      skip_q         <= skip_n;
      data_q         <= data_n;
      hoff           <= hoff_n;
      sync_o         <= run_n && (cnt_x < sync_len);
      hit_o          <= run_n && hit_en &&
                        (cnt_x >= hoff_x) && (cnt_x < hend_x);
      env_n_o        <= !((run_n && (cnt_x < sync_len)) ||
                          (run_n && hit_en &&
                           (cnt_x >= hoff_x) && (cnt_x < hend_x)));
      axis_o         <= run_n & axis_n;
      period_start_o <= run_n && (cnt_n == 19'd0);
    end
  end

endmodule

// File: tb/tb_lighthouse_sweep_tx.sv
// Directed bench for lighthouse_sweep_tx, run with a scaled clock
// (4000-cycle period, sync 30+5*code, hit 25) to keep runtime short.
module tb_lighthouse_sweep_tx;

  localparam int SW = 4000;

  logic        clk;
  logic        rst;
  logic        enable_i;
  logic        skip_i;
  logic        ootx_valid_i;
  logic        ootx_bit_i;
  logic        ootx_ready_o;
  logic [18:0] hit_x_i;
  logic [18:0] hit_y_i;
  logic        sync_o;
  logic        hit_o;
  logic        env_n_o;
  logic        axis_o;
  logic        period_start_o;

  int passed = 0;
  int total  = 0;

  lighthouse_sweep_tx #(
    .CLK_SPEED    (480_000),
    .SWEEP_CYCLES (4000),
    .SYNC_BASE    (30),
    .SYNC_STEP    (5),
    .HIT_CYCLES   (25)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable_i       (enable_i),
    .skip_i         (skip_i),
    .ootx_valid_i   (ootx_valid_i),
    .ootx_bit_i     (ootx_bit_i),
    .ootx_ready_o   (ootx_ready_o),
    .hit_x_i        (hit_x_i),
    .hit_y_i        (hit_y_i),
    .sync_o         (sync_o),
    .hit_o          (hit_o),
    .env_n_o        (env_n_o),
    .axis_o         (axis_o),
    .period_start_o (period_start_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full period; the first edge must be the period-start edge.
  task automatic run_period(input string tag,
                            input logic exp_axis,
                            input int exp_sync,
                            input int exp_hfirst,
                            input int exp_hcnt);
    int nsync, nhit, nps, bad_sync, bad_hit, bad_env, bad_axis;
    logic ps0, rdy_mid, rdy_last, want_hit;
    nsync = 0; nhit = 0; nps = 0;
    bad_sync = 0; bad_hit = 0; bad_env = 0; bad_axis = 0;
    ps0 = 1'b0; rdy_mid = 1'b0; rdy_last = 1'b0;
    for (int i = 0; i < SW; i++) begin
      step();
      want_hit = (exp_hcnt > 0) && (i >= exp_hfirst) &&
                 (i < exp_hfirst + exp_hcnt);
      if (i == 0) begin
        ps0 = period_start_o;
        skip_i = 1'b0;
        ootx_valid_i = 1'b0;
      end
      if (i == 5) begin
        hit_x_i = 19'd500;
        hit_y_i = 19'd500;
        skip_i = 1'b1;
      end
      if (i == SW / 2) rdy_mid = ootx_ready_o;
      if (i == SW - 1) rdy_last = ootx_ready_o;
      if (period_start_o === 1'b1) nps++;
      if (sync_o === 1'b1) nsync++;
      if (hit_o === 1'b1) nhit++;
      if (sync_o !== (i < exp_sync)) bad_sync++;
      if (hit_o !== want_hit) bad_hit++;
      if (env_n_o !== ~(sync_o | hit_o)) bad_env++;
      if (axis_o !== exp_axis) bad_axis++;
    end
    skip_i = 1'b0;
    chk({tag, "_ps0"}, ps0, 1);
    chk({tag, "_ps_count"}, nps, 1);
    chk({tag, "_axis_bad"}, bad_axis, 0);
    chk({tag, "_sync_len"}, nsync, exp_sync);
    chk({tag, "_sync_bad"}, bad_sync, 0);
    chk({tag, "_hit_len"}, nhit, exp_hcnt);
    chk({tag, "_hit_bad"}, bad_hit, 0);
    chk({tag, "_env_bad"}, bad_env, 0);
    chk({tag, "_rdy_mid"}, rdy_mid, 0);
    chk({tag, "_rdy_last"}, rdy_last, 1);
  endtask

  initial begin
    rst = 1'b1;
    enable_i = 1'b0;
    skip_i = 1'b0;
    ootx_valid_i = 1'b0;
    ootx_bit_i = 1'b0;
    hit_x_i = 19'd2000;
    hit_y_i = 19'd2000;
    #12;
    chk("rst_sync", sync_o, 0);
    chk("rst_hit", hit_o, 0);
    chk("rst_ps", period_start_o, 0);
    chk("rst_axis", axis_o, 0);
    chk("rst_env", env_n_o, 1);
    chk("rst_rdy_off", ootx_ready_o, 0);
    enable_i = 1'b1;
    #1;
    chk("rst_rdy_on", ootx_ready_o, 1);
    @(negedge clk);
    rst = 1'b0;

    run_period("p0", 1'b0, 30, 2000, 25);
    hit_x_i = 19'd2000; hit_y_i = 19'd2000;
    run_period("p1", 1'b1, 35, 2000, 25);

    hit_x_i = 19'd2000; hit_y_i = 19'd2000;
    ootx_valid_i = 1'b1; ootx_bit_i = 1'b1;
    chk("p2_xfer", {ootx_valid_i, ootx_ready_o}, 2'b11);
    run_period("p2", 1'b0, 40, 2000, 25);

    hit_x_i = 19'd2000; hit_y_i = 19'd2000;
    skip_i = 1'b1; ootx_valid_i = 1'b1; ootx_bit_i = 1'b1;
    run_period("p3", 1'b1, 65, 0, 0);

    hit_x_i = 19'd69; hit_y_i = 19'd2000;
    run_period("p4_h69", 1'b0, 30, 0, 0);
    hit_x_i = 19'd2000; hit_y_i = 19'd70;
    run_period("p5_h70", 1'b1, 35, 70, 25);
    hit_x_i = 19'd3975; hit_y_i = 19'd2000;
    run_period("p6_h3975", 1'b0, 30, 3975, 25);
    hit_x_i = 19'd2000; hit_y_i = 19'd3976;
    run_period("p7_h3976", 1'b1, 35, 0, 0);

    // Abort mid-period while the hit is active.
    hit_x_i = 19'd990; hit_y_i = 19'd990;
    for (int i = 0; i <= 1000; i++) step();
    chk("dis_hit_before", hit_o, 1);
    chk("dis_axis_before", axis_o, 0);
    enable_i = 1'b0;
    #1;
    chk("dis_rdy", ootx_ready_o, 0);
    step();
    chk("dis_sync", sync_o, 0);
    chk("dis_hit", hit_o, 0);
    chk("dis_env", env_n_o, 1);
    chk("dis_ps", period_start_o, 0);
    step();
    chk("dis_idle_hit", hit_o, 0);
    chk("dis_idle_ps", period_start_o, 0);
    enable_i = 1'b1;
    #1;
    chk("re_rdy", ootx_ready_o, 1);
    run_period("p_re", 1'b0, 30, 990, 25);

    // Reset during the sync of an axis-1 period carrying an OOTX bit.
    hit_x_i = 19'd2000; hit_y_i = 19'd2000;
    ootx_valid_i = 1'b1; ootx_bit_i = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("mid_sync_on", sync_o, 1);
    chk("mid_axis", axis_o, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sync", sync_o, 0);
    chk("arst_hit", hit_o, 0);
    chk("arst_ps", period_start_o, 0);
    chk("arst_axis", axis_o, 0);
    chk("arst_env", env_n_o, 1);
    @(negedge clk);
    ootx_valid_i = 1'b0;
    rst = 1'b0;
    run_period("p_after_rst", 1'b0, 30, 2000, 25);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
